// File: rtl/trigger_activator.sv
// Stimulus generator driving the r1..r4 rare-event code into a counter-based trigger
// block and timing its trig response. Optional CLEAR preamble on start: ACTIVATOR_CLEAR_EN.
`timescale 1ns/1ps
module trigger_activator #(
   parameter int unsigned TARGET_COUNT = 4096,
   parameter int unsigned WAIT_MAX     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        trig,
   output logic        r1,
   output logic        r2,
   output logic        r3,
   output logic        r4,
   output logic        busy,
   output logic        done,
   output logic        success,
   output logic [13:0] cycles
);

   localparam int unsigned DW = 13;
   localparam int unsigned WW = 8;
   localparam int unsigned CW = 14;
   localparam int unsigned IW = 4;
   localparam logic [3:0] CODE_HOLD  = 4'b0000;
   localparam logic [3:0] CODE_CLEAR = 4'b1101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DRIVE,
      S_WAIT,
      S_FIN
   } state_t;

   state_t          state;
   logic [3:0]      code;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic [DW-1:0]   dcnt;
   logic [WW-1:0]   wcnt;
   logic            clr_abort;
   logic [CW-1:0]   cycles_inc;

   // Nine counting codes in emission order; 1101 (clear) is deliberately absent.
   function automatic logic [3:0] drive_code(input logic [IW-1:0] i);
      case (i)
         4'd0:    drive_code = 4'b1000;
         4'd1:    drive_code = 4'b1001;
         4'd2:    drive_code = 4'b1010;
         4'd3:    drive_code = 4'b1011;
         4'd4:    drive_code = 4'b0100;
         4'd5:    drive_code = 4'b0101;
         4'd6:    drive_code = 4'b0110;
         4'd7:    drive_code = 4'b0111;
         4'd8:    drive_code = 4'b1100;
         default: drive_code = 4'b1000;
      endcase
   endfunction

   assign idx_nxt    = (idx == IW'(8)) ? IW'(0) : idx + IW'(1);
   assign cycles_inc = (cycles == '1) ? cycles : cycles + CW'(1);
   assign {r1, r2, r3, r4} = code;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         code      <= CODE_HOLD;
         idx       <= '0;
         dcnt      <= '0;
         wcnt      <= '0;
         clr_abort <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         success   <= 1'b0;
         cycles    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               code <= CODE_HOLD;
               busy <= 1'b0;
               if (start) begin
                  success   <= 1'b0;
                  cycles    <= '0;
                  busy      <= 1'b1;
                  clr_abort <= 1'b0;
                  dcnt      <= '0;
                  wcnt      <= '0;
                  idx       <= '0;
`ifdef ACTIVATOR_CLEAR_EN
                  state     <= S_CLEAR;
                  code      <= CODE_CLEAR;
`else
                  state     <= S_DRIVE;
                  code      <= drive_code(IW'(0));
`endif
               end
            end

            // Clear preamble before DRIVE, or the abort tail back to IDLE.
            S_CLEAR: begin
               if (clr_abort) begin
                  state     <= S_IDLE;
                  code      <= CODE_HOLD;
                  busy      <= 1'b0;
                  clr_abort <= 1'b0;
               end else begin
                  state <= S_DRIVE;
                  code  <= drive_code(IW'(0));
                  idx   <= '0;
                  dcnt  <= '0;
               end
            end

            S_DRIVE: begin
               cycles <= cycles_inc;
               if (abort) begin
                  state     <= S_CLEAR;
                  code      <= CODE_CLEAR;
                  clr_abort <= 1'b1;
                  success   <= 1'b0;
               end else if (trig) begin
                  state   <= S_FIN;
                  code    <= CODE_HOLD;
                  done    <= 1'b1;
                  success <= 1'b1;
               end else if (dcnt == DW'(TARGET_COUNT - 1)) begin
                  state <= S_WAIT;
                  code  <= CODE_HOLD;
                  wcnt  <= '0;
               end else begin
                  dcnt <= dcnt + DW'(1);
                  idx  <= idx_nxt;
                  code <= drive_code(idx_nxt);
               end
            end

            S_WAIT: begin
               cycles <= cycles_inc;
               if (abort) begin
                  state     <= S_CLEAR;
                  code      <= CODE_CLEAR;
                  clr_abort <= 1'b1;
                  success   <= 1'b0;
               end else if (trig) begin
                  state   <= S_FIN;
                  done    <= 1'b1;
                  success <= 1'b1;
               end else if (wcnt == WW'(WAIT_MAX - 1)) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end else begin
                  wcnt <= wcnt + WW'(1);
               end
            end

            S_FIN: begin
               state <= S_IDLE;
               code  <= CODE_HOLD;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               code  <= CODE_HOLD;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_activator.sv
// Bench for trigger_activator: directed and randomized attempts checked cycle by cycle
// against an attempt-level model of the code sequence, exit condition and result.
`timescale 1ns/1ps
module tb_trigger_activator;

   localparam int unsigned T = 24;
   localparam int unsigned W = 5;
`ifdef ACTIVATOR_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        trig = 1'b0;
   logic        r1, r2, r3, r4, busy, done, success;
   logic [13:0] cycles;
   logic [3:0]  code;

   int tests = 0;
   int fails = 0;
   logic [3:0] tbl [9] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100,
                           4'b0101, 4'b0110, 4'b0111, 4'b1100};

   trigger_activator #(.TARGET_COUNT(T), .WAIT_MAX(W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
      .r1(r1), .r2(r2), .r3(r3), .r4(r4),
      .busy(busy), .done(done), .success(success), .cycles(cycles)
   );

   assign code = {r1, r2, r3, r4};
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_code"},    16'(code),    16'd0);
      chk({tag, "_busy"},    16'(busy),    16'd0);
      chk({tag, "_done"},    16'(done),    16'd0);
      chk({tag, "_success"}, 16'(success), 16'd0);
      chk({tag, "_cycles"},  16'(cycles),  16'd0);
   endtask

   // One attempt: trig high from active cycle trig_at on (0 = never), abort pulsed in
   // active cycle abort_at (0 = never), rst low in active cycle rst_at (0 = never).
   task automatic run_attempt(input int trig_at, input int abort_at, input int rst_at,
                              input bit hold);
      bit aborted;
      bit hit;
      int end_s;
      logic [3:0] ec;
      aborted = 1'b0;
      hit     = 1'b0;
      end_s   = 0;
      trig  = (trig_at == 1);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      chk("start_success", 16'(success), 16'd0);
      chk("start_cycles",  16'(cycles),  16'd0);
      if (CLR) begin
         chk("clear_code", 16'(code), 16'hd);
         chk("clear_busy", 16'(busy), 16'd1);
         tick();
      end
      for (int s = 1; s <= int'(T + W); s++) begin
         ec = (s <= int'(T)) ? tbl[(s - 1) % 9] : 4'b0000;
         chk("active_code", 16'(code), 16'(ec));
         chk("active_busy", 16'(busy), 16'd1);
         chk("active_done", 16'(done), 16'd0);
         trig  = (trig_at != 0) && (s >= trig_at);
         abort = (s == abort_at);
         if (s == rst_at) begin
            rst = 1'b0;
            tick();
            rst   = 1'b1;
            trig  = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            chk_all_zero("reset_mid");
            return;
         end
         tick();
         end_s = s;
         if (abort) begin
            aborted = 1'b1;
            break;
         end
         if (trig) begin
            hit = 1'b1;
            break;
         end
      end
      trig  = 1'b0;
      abort = 1'b0;
      if (aborted) begin
         chk("abort_code",    16'(code),    16'hd);
         chk("abort_busy",    16'(busy),    16'd1);
         chk("abort_done",    16'(done),    16'd0);
         chk("abort_success", 16'(success), 16'd0);
         tick();
         chk("abort_idle_busy", 16'(busy), 16'd0);
         chk("abort_idle_code", 16'(code), 16'd0);
         chk("abort_idle_done", 16'(done), 16'd0);
      end else begin
         chk("fin_code",    16'(code),    16'd0);
         chk("fin_busy",    16'(busy),    16'd1);
         chk("fin_done",    16'(done),    16'd1);
         chk("fin_success", 16'(success), 16'(hit));
         chk("fin_cycles",  16'(cycles),  16'(end_s));
         tick();
         chk("idle_busy",    16'(busy),    16'd0);
         chk("idle_done",    16'(done),    16'd0);
         chk("idle_code",    16'(code),    16'd0);
         chk("idle_success", 16'(success), 16'(hit));
         chk("idle_cycles",  16'(cycles),  16'(end_s));
      end
   endtask

   initial begin
      int ta, aa, ra;
      bit hd;
      rst = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b1;
      tick();
      chk("idle_after_reset_busy", 16'(busy), 16'd0);

      run_attempt(T + 1, 0, 0, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk_all_zero("reset_idle");

      run_attempt(0, 0, 0, 1'b0);
      run_attempt(1, 0, 0, 1'b0);
      run_attempt(0, 10, 0, 1'b0);
      run_attempt(7, 7, 0, 1'b0);
      run_attempt(0, T + 2, 0, 1'b0);
      run_attempt(0, 0, 12, 1'b0);
      run_attempt(0, 0, 0, 1'b0);
      run_attempt(T, 0, 0, 1'b0);
      run_attempt(5, 0, 0, 1'b1);
      run_attempt(0, 0, 0, 1'b0);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", 16'(busy), 16'd0);
      chk("idle_abort_code", 16'(code), 16'd0);

      for (int n = 0; n < 30; n++) begin
         ta = int'($urandom_range(0, T + W + 1));
         aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + W)) : 0;
         ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, T + W)) : 0;
         hd = 1'($urandom_range(0, 1));
         run_attempt(ta, aa, ra, hd);
      end
      start = 1'b0;
      tick();
      chk("final_idle_busy", 16'(busy), 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/trigger_activator.md
# trigger_activator

Stimulus generator that drives the four-bit rare-event inputs (r1..r4) of the counter-based trigger block and reports whether, and after how many cycles, its trigger output asserts. It is the initiator side of that trigger interface. It sits in the Trojan-detection bench and evaluation harness, between the test sequencer (start/abort) and the design under evaluation (r1..r4 out, trig in).

## Interface
- TARGET_COUNT, 4096: number of qualifying pattern cycles driven in DRIVE, range 1..8191.
- WAIT_MAX, 64: WAIT-state cycles allowed for trig before timeout, range 1..255.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin activation attempt; sampled only in IDLE.
- abort  in  1  cancel attempt; sampled in DRIVE and WAIT.
- trig  in  1  trigger output of the block under evaluation.
- r1, r2, r3, r4  out  1 each  pattern bits, registered; {r1,r2,r3,r4} forms the code.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when an attempt completes (not on abort).
- success  out  1  trig observed in the last completed attempt.
- cycles  out  14  DRIVE+WAIT cycles up to and including first trig-high sample; saturates at 16383.

## Operation
- States: IDLE, CLEAR, DRIVE, WAIT, FIN.
- Reset: rst low at an edge forces IDLE. Code=0000, busy=0, done=0, success=0, cycles=0, and all internal counters=0. This applies from any state, including mid-attempt.
- IDLE: code=0000. On start=1:
  - success and cycles are cleared.
  - Next state is DRIVE, or CLEAR when the configuration macro is defined.
- CLEAR: code=1101 for one cycle, then DRIVE. Not counted in cycles. trig is not sampled.
- DRIVE: code cycles through the nine counting codes in order: 1000, 1001, 1010, 1011, 0100, 0101, 0110, 0111, 1100, then wraps to 1000.
  - The code index restarts at 1000 on every DRIVE entry.
  - 1101 is never emitted here.
  - Exactly TARGET_COUNT DRIVE cycles, then WAIT.
- WAIT: code=0000, which the downstream block treats as hold. Up to WAIT_MAX cycles, then FIN with success=0.
- trig sampling:
  - trig is sampled at the end of every DRIVE and WAIT cycle.
  - On the first high sample: success=1, cycles is latched, next state FIN. This exit also applies from DRIVE, cutting DRIVE short.
- FIN: code=0000, done=1 for one cycle, then IDLE. success and cycles hold until the next start or reset.
- abort=1 in DRIVE or WAIT:
  - Next state is CLEAR-then-IDLE: one cycle of code 1101, busy=1, no done pulse, success=0.
  - abort has priority over a trig sample in the same cycle.
- start while busy is ignored. abort in IDLE, CLEAR or FIN is ignored.
- cycles counter increments once per DRIVE/WAIT cycle, saturating. The 14-bit width covers 8191+255.

## Timing
- Outputs are registered. The code for a state appears in the cycle that state is occupied.
- Start latency: start sampled at edge N gives the first DRIVE code (1000) during cycle N+1. With the macro, 1101 appears in cycle N+1 and 1000 in N+2.
- Downstream samples each code at the edge ending its cycle. After TARGET_COUNT=4096 DRIVE cycles, trig rises in WAIT cycle 1 and is sampled at its end, so cycles=4097.
- done asserts the cycle after the trig-high sample. busy falls with the IDLE return, the cycle after done.
- Abort: abort sampled at edge M gives 1101 during cycle M+1 and IDLE (busy=0) at cycle M+2.

## Configuration
- Macro ACTIVATOR_CLEAR_EN.
- Defined: every start inserts the one-cycle CLEAR preamble (code 1101). This zeroes the downstream counter so each attempt measures from zero.
- Undefined: CLEAR is entered only on abort. The attempt begins from whatever count the downstream block holds, so a pre-armed trig can yield cycles=1.

## Test plan
- Macro defined, TARGET_COUNT=4096, 13-bit reference trigger model attached, start pulse -> code 1101 one cycle, then 4096 DRIVE codes in the listed order, trig high in WAIT cycle 1, done pulse, success=1, cycles=4097.
- Trigger model input tied off (trig=0), WAIT_MAX=64 -> after 4096 DRIVE + 64 WAIT cycles, done=1, success=0, cycles=4160.
- Macro undefined, trig already 1 at start -> first DRIVE cycle samples high, success=1, cycles=1, DRIVE cut short.
- abort asserted at DRIVE cycle 100 -> next cycle code=1101, then IDLE with busy=0, no done pulse, success=0; reference model counter reads 0.
- rst low at DRIVE cycle 2000 -> next cycle all outputs 0, state IDLE; a following start runs a full 4096-cycle attempt from code 1000.
- start held high throughout an attempt -> ignored while busy; a new attempt begins only after the IDLE return, with success and cycles cleared at that start.
